// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Drives all 16 input vectors of a 4-input combinational function under test.
//   For each vector it holds the vector for SETTLE_CYC cycles, then samples F
//   during one extra cycle. It captures the observed truth table and checks it
//   against a golden table.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   start            scan request, only looked at while idle
//   expected[15:0]   golden table, bit i = required F for vector i
//   f_in             F from the function under test
//   a_out..d_out     stimulus, {a,b,c,d} = vector index (a is the MSB)
//   busy             high while vectors are being applied
//   done             one-cycle pulse when the scan finishes
//   tt[15:0]         captured table, bit i = F observed for vector i
//   err_cnt[4:0]     number of mismatching vectors (0..16)
//   first_err[3:0]   lowest mismatching vector, qualified by first_err_valid
//   first_err_valid  at least one mismatch seen
//   pass             last completed scan had no mismatches
module truth_table_scanner #(
  parameter int SETTLE_CYC = 1  // 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_err,
  output logic        first_err_valid,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  logic       mismatch;

  assign mismatch = (f_in != expected[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 4'd15) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      settle_cnt      <= '0;
      tt              <= '0;
      err_cnt         <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          idx             <= '0;
          settle_cnt      <= '0;
          tt              <= '0;
          err_cnt         <= '0;
          first_err       <= '0;
          first_err_valid <= 1'b0;
          pass            <= 1'b0;
        end
        SETTLE: if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: begin
          tt[idx] <= f_in;
          if (mismatch) begin
            err_cnt <= err_cnt + 5'd1;
            if (!first_err_valid) begin
              first_err       <= idx;
              first_err_valid <= 1'b1;
            end
          end
          if (idx != 4'd15) begin
            idx        <= idx + 4'd1;
            settle_cnt <= '0;
          end else begin
            // Fold in the vector-15 comparison being registered this same edge.
            pass <= ((err_cnt + {4'd0, mismatch}) == 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free
  // and drop to zero the moment reset asserts.
  always_comb begin
    busy = (state == SETTLE) || (state == SAMPLE);
    done = (state == DONE);
    {a_out, b_out, c_out, d_out} = busy ? idx : 4'd0;
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start1, start3;
  logic [15:0] expected, golden;
  int          mode;   // 0: model F, 1: tied 0, 2: tied 1
  bit          sel;    // 0: SETTLE_CYC=1 instance, 1: SETTLE_CYC=3 instance

  logic        a1, b1, c1, d1, busy1, done1, fev1, pass1, f1;
  logic [15:0] tt1;
  logic [4:0]  err1;
  logic [3:0]  fe1, vec1;
  logic        a3, b3, c3, d3, busy3, done3, fev3, pass3, f3;
  logic [15:0] tt3;
  logic [4:0]  err3;
  logic [3:0]  fe3, vec3;

  assign vec1 = {a1, b1, c1, d1};
  assign vec3 = {a3, b3, c3, d3};
  assign f1   = (mode == 0) ? golden[vec1] : (mode == 2);
  assign f3   = golden[vec3];

  truth_table_scanner #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected), .f_in(f1),
    .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1), .busy(busy1), .done(done1),
    .tt(tt1), .err_cnt(err1), .first_err(fe1), .first_err_valid(fev1), .pass(pass1));

  truth_table_scanner #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected), .f_in(f3),
    .a_out(a3), .b_out(b3), .c_out(c3), .d_out(d3), .busy(busy3), .done(done3),
    .tt(tt3), .err_cnt(err3), .first_err(fe3), .first_err_valid(fev3), .pass(pass3));

  logic        done_s, busy_s, fev_s, pass_s;
  logic [3:0]  vec_s, fe_s;
  logic [15:0] tt_s;
  logic [4:0]  err_s;
  assign done_s = sel ? done3 : done1;
  assign busy_s = sel ? busy3 : busy1;
  assign vec_s  = sel ? vec3  : vec1;
  assign tt_s   = sel ? tt3   : tt1;
  assign err_s  = sel ? err3  : err1;
  assign fe_s   = sel ? fe3   : fe1;
  assign fev_s  = sel ? fev3  : fev1;
  assign pass_s = sel ? pass3 : pass1;

  int tests = 0;
  int fails = 0;
  int done_edge, done_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag, input logic [15:0] e_tt, input logic [4:0] e_err,
                             input logic [3:0] e_fe, input logic e_fev, input logic e_pass);
    chk({tag, ".tt"},    64'(tt_s),   64'(e_tt));
    chk({tag, ".err"},   64'(err_s),  64'(e_err));
    chk({tag, ".fe"},    64'(fe_s),   64'(e_fe));
    chk({tag, ".fev"},   64'(fev_s),  64'(e_fev));
    chk({tag, ".pass"},  64'(pass_s), 64'(e_pass));
  endtask

  // Edge 0 is the rising edge that accepts start. Every later edge n is observed
  // 1 ns after it. The first edge with done high and the number of done cycles
  // are recorded.
  task automatic run_scan(input bit s_sel, input int s, input bit repulse, input bit rel,
                          output int d_edge, output int d_cnt);
    int n_total;
    n_total = 16 * (s + 1) + 4;
    d_edge  = -1;
    d_cnt   = 0;
    sel     = s_sel;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    if (s_sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    chk("busy_after_start", 64'(busy_s), 64'(1));
    for (int n = 1; n <= n_total; n++) begin
      @(posedge clk); #1;
      if (repulse) start1 = (n == 4 || n == 19);
      if (done_s) begin
        if (d_edge < 0) d_edge = n;
        d_cnt++;
      end
      if (n == 5 * (s + 1)) begin
        chk("vec5_applied", 64'(vec_s), 64'(4'd5));
        chk("busy_mid",     64'(busy_s), 64'(1));
      end
      if (n == 16 * (s + 1)) begin
        chk("busy_in_done", 64'(busy_s), 64'(0));
        chk("vec_in_done",  64'(vec_s),  64'(0));
      end
    end
    start1 = 1'b0;
    chk("busy_after", 64'(busy_s), 64'(0));
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
    expected = 16'hAAF8; golden = 16'hAAF8; mode = 0; sel = 1'b0;
    #12;
    chk("reset_dut1", 64'({vec1, busy1, done1, tt1, err1, fe1, fev1, pass1}), 64'(0));
    chk("reset_dut3", 64'({vec3, busy3, done3, tt3, err3, fe3, fev3, pass3}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_dut1", 64'({vec1, busy1, done1, tt1, err1, fe1, fev1, pass1}), 64'(0));
    chk("idle_dut3", 64'({vec3, busy3, done3, tt3, err3, fe3, fev3, pass3}), 64'(0));

    // Model F agrees with the golden table.
    mode = 0; expected = 16'hAAF8;
    run_scan(1'b0, 1, 1'b0, 1'b0, done_edge, done_cnt);
    chk("s1_done_edge", 64'(done_edge), 64'(32));
    chk("s1_done_cnt",  64'(done_cnt),  64'(1));
    chk_results("s1", 16'hAAF8, 5'd0, 4'd0, 1'b0, 1'b1);

    // F stuck at 0: the nine ones in the golden table all mismatch, lowest is 3.
    mode = 1;
    run_scan(1'b0, 1, 1'b0, 1'b0, done_edge, done_cnt);
    chk("s0_done_edge", 64'(done_edge), 64'(32));
    chk_results("s0", 16'h0000, 5'd9, 4'd3, 1'b1, 1'b0);

    // F stuck at 1 against all-zero golden; extra start pulses must be ignored.
    mode = 2; expected = 16'h0000;
    run_scan(1'b0, 1, 1'b1, 1'b0, done_edge, done_cnt);
    chk("sall_done_edge", 64'(done_edge), 64'(32));
    chk("sall_done_cnt",  64'(done_cnt),  64'(1));
    chk_results("sall", 16'hFFFF, 5'd16, 4'd0, 1'b1, 1'b0);

    // Reset in the middle of vector 7.
    mode = 0; expected = 16'hAAF8;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("mid_vec7", 64'(vec1), 64'(7));
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({vec1, busy1, done1, tt1, err1, fe1, fev1, pass1}), 64'(0));
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done1) dn++;
    end
    chk("no_done_in_reset", 64'(dn), 64'(0));
    // Release with start already high: accepted on the first edge.
    run_scan(1'b0, 1, 1'b0, 1'b1, done_edge, done_cnt);
    chk("rst_done_edge", 64'(done_edge), 64'(32));
    chk("rst_done_cnt",  64'(done_cnt),  64'(1));
    chk_results("rst", 16'hAAF8, 5'd0, 4'd0, 1'b0, 1'b1);

    // Longer settle time.
    run_scan(1'b1, 3, 1'b0, 1'b0, done_edge, done_cnt);
    chk("s3_done_edge", 64'(done_edge), 64'(64));
    chk("s3_done_cnt",  64'(done_cnt),  64'(1));
    chk_results("s3", 16'hAAF8, 5'd0, 4'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 1, giving the number of cycles each input vector is held before F is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 expected  input  16  golden truth table; bit i = required F for vector i.
REQ-006 f_in  input  1  F output of the function-under-test, combinational from a_out..d_out.
REQ-007 a_out, b_out, c_out, d_out  output  1 each  stimulus to A, B, C, D; a_out = MSB of vector index.
REQ-008 busy  output  1  high while a scan is in progress.
REQ-009 done  output  1  one-cycle pulse on scan completion.
REQ-010 tt  output  16  captured truth table; bit i = f_in sampled for vector i.
REQ-011 err_cnt  output  5  number of mismatching vectors, 0..16.
REQ-012 first_err  output  4  index of lowest mismatching vector; valid only when first_err_valid = 1.
REQ-013 first_err_valid  output  1  at least one mismatch recorded.
REQ-014 pass  output  1  registered; 1 iff completed scan had err_cnt = 0.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; 4-bit vector index idx; settle counter 4 bits.
REQ-016 IDLE: a..d_out = 0000, busy = 0; start = 1 at an edge -> idx = 0, settle counter = 0, tt/err_cnt/first_err/first_err_valid/pass cleared, go SETTLE.
REQ-017 SETTLE and SAMPLE: {a_out,b_out,c_out,d_out} = idx; busy = 1.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then go SAMPLE.
REQ-019 SAMPLE lasts one cycle; at its closing edge tt[idx] <= f_in; if f_in != expected[idx], err_cnt increments and, if first_err_valid = 0, first_err <= idx and first_err_valid <= 1.
REQ-020 SAMPLE with idx < 15 -> idx + 1, settle counter cleared, go SETTLE; idx = 15 -> go DONE, pass <= (final err_cnt == 0), including the vector-15 comparison.
REQ-021 idx SHALL NOT wrap; vector 15 is the last and scan ends there.
REQ-022 DONE: done = 1 and busy = 0 for exactly one cycle, a..d_out = 0000, then IDLE.
REQ-023 Latency: with start accepted at edge 0, vector i sampled at edge (i+1)*(SETTLE_CYC+1); DONE entered at edge 16*(SETTLE_CYC+1).
REQ-024 start while busy or in DONE SHALL be ignored, with no restart and no effect on results.
REQ-025 tt, err_cnt, first_err, first_err_valid, pass SHALL hold after DONE until the next accepted start.
REQ-026 expected SHALL be used as presented at each SAMPLE edge; it is held stable during a scan.
REQ-027 err_cnt SHALL saturate-free count to 16; 5-bit width covers all-mismatch.

Reset
REQ-028 rst_n = 0 SHALL immediately, without clk, force state IDLE, idx = 0, a..d_out = 0000, busy = 0, done = 0, tt = 0, err_cnt = 0, first_err = 0, first_err_valid = 0, pass = 0.
REQ-029 Reset mid-scan SHALL discard partial results; no done pulse follows; the next start runs a full scan from vector 0.
REQ-030 After rst_n rises, start is honoured at the first rising edge.

Verification
REQ-031 Reset, idle 5 cycles -> all outputs 0, a..d_out = 0000.
REQ-032 SETTLE_CYC = 1, f_in driven by model F(i) = 1 for i in {3,4,5,6,7,9,11,13,15}, expected = 16'hAAF8, start pulse -> done at edge 32, tt = 16'hAAF8, err_cnt = 0, pass = 1, first_err_valid = 0.
REQ-033 f_in tied 0, expected = 16'hAAF8 -> tt = 16'h0000, err_cnt = 9, first_err = 3, first_err_valid = 1, pass = 0.
REQ-034 f_in tied 1, expected = 16'h0000 -> err_cnt = 16, first_err = 0, pass = 0; also re-pulse start at edges 5 and 20 -> exactly one done, at edge 32.
REQ-035 rst_n low while idx = 7 -> all outputs 0 asynchronously, no done; new start -> full clean scan matching REQ-032.
REQ-036 SETTLE_CYC = 3 -> each vector held 4 cycles, done at edge 64, results as REQ-032.
